// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl
//   Hazard controller for a five-stage pipeline (F/D/E/M/W) using the
//   Tuse/Tnew method. It tracks the register writers currently in E, M
//   and W. From that state and the D-stage operands it generates:
//   - a stall request,
//   - forwarding selects for the D and E operands,
//   - a saturating count of stalled cycles.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   d_rs, d_rt             D-stage source register addresses
//   d_rs_tuse, d_rt_tuse   cycles after D until operand needed (3 = unused)
//   d_regwrite, d_wa       D-stage write intent and destination
//   d_tnew                 cycles after E-entry until the result exists
//   flush                  squash every in-flight instruction
//   stall                  freeze PC and F/D, bubble into E
//   fwd_d_rs, fwd_d_rt     D operand source: 0 GRF, 1 E result, 2 M result
//   fwd_e_rs, fwd_e_rt     E operand source: 0 pipe reg, 1 M result, 2 W result
//   stall_cnt              saturating stalled-cycle counter
module grf_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_rs_tuse,
  input  logic [1:0]       d_rt_tuse,
  input  logic             d_regwrite,
  input  logic [4:0]       d_wa,
  input  logic [1:0]       d_tnew,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       e_valid, m_valid, w_valid;
  logic [4:0] e_wa, m_wa, w_wa;
  logic [1:0] e_tnew, m_tnew, w_tnew;
  logic [4:0] e_rs, e_rt;

  // A write to $0 is never a producer.
  function automatic logic hit(input logic v, input logic [4:0] wa,
                               input logic [4:0] r);
    return v && (wa != 5'd0) && (wa == r);
  endfunction

  function automatic logic [1:0] dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // The youngest matching producer decides. A matching E entry hides M
  // even when E's result is not ready yet. W is never a stall source,
  // because the GRF bypasses its write internally.
  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic eh, input logic [1:0] et,
                                     input logic mh, input logic [1:0] mt);
    if (tuse == 2'd3 || r == 5'd0) return 1'b0;
    if (eh) return et > tuse;
    if (mh) return mt > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_fwd_d(input logic eh, input logic [1:0] et,
                                           input logic mh, input logic [1:0] mt);
    if (eh) return (et == 2'd0) ? 2'd1 : 2'd0;
    if (mh && mt == 2'd0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] src_fwd_e(input logic mh, input logic [1:0] mt,
                                           input logic wh, input logic [1:0] wt);
    if (mh) return (mt == 2'd0) ? 2'd1 : 2'd0;
    if (wh && wt == 2'd0) return 2'd2;
    return 2'd0;
  endfunction

  logic eh_rs, eh_rt, mh_rs, mh_rt;
  logic me_rs, me_rt, we_rs, we_rt;

  always_comb begin
    eh_rs = hit(e_valid, e_wa, d_rs);
    eh_rt = hit(e_valid, e_wa, d_rt);
    mh_rs = hit(m_valid, m_wa, d_rs);
    mh_rt = hit(m_valid, m_wa, d_rt);
    me_rs = hit(m_valid, m_wa, e_rs);
    me_rt = hit(m_valid, m_wa, e_rt);
    we_rs = hit(w_valid, w_wa, e_rs);
    we_rt = hit(w_valid, w_wa, e_rt);

    stall    = src_stall(d_rs, d_rs_tuse, eh_rs, e_tnew, mh_rs, m_tnew) |
               src_stall(d_rt, d_rt_tuse, eh_rt, e_tnew, mh_rt, m_tnew);
    fwd_d_rs = src_fwd_d(eh_rs, e_tnew, mh_rs, m_tnew);
    fwd_d_rt = src_fwd_d(eh_rt, e_tnew, mh_rt, m_tnew);
    fwd_e_rs = src_fwd_e(me_rs, m_tnew, we_rs, w_tnew);
    fwd_e_rt = src_fwd_e(me_rt, m_tnew, we_rt, w_tnew);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= 1'b0;
      e_wa      <= '0;
      e_tnew    <= '0;
      e_rs      <= '0;
      e_rt      <= '0;
      m_valid   <= 1'b0;
      m_wa      <= '0;
      m_tnew    <= '0;
      w_valid   <= 1'b0;
      w_wa      <= '0;
      w_tnew    <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      // Clearing the E operand addresses keeps the E forwards quiet
      // in the cycle after a squash.
      e_valid <= 1'b0;
      e_rs    <= '0;
      e_rt    <= '0;
      m_valid <= 1'b0;
      w_valid <= 1'b0;
    end else begin
      m_valid <= e_valid;
      m_wa    <= e_wa;
      m_tnew  <= dec(e_tnew);
      w_valid <= m_valid;
      w_wa    <= m_wa;
      w_tnew  <= dec(m_tnew);
      if (stall) begin
        e_valid <= 1'b0;
        e_wa    <= '0;
        e_tnew  <= '0;
        e_rs    <= '0;
        e_rt    <= '0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        e_valid <= d_regwrite;
        e_wa    <= d_wa;
        e_tnew  <= d_tnew;
        e_rs    <= d_rs;
        e_rt    <= d_rt;
      end
    end
  end

endmodule
